// File: rtl/fifo_mon_pkg.sv
// Shared definitions for the FIFO write-side pointer monitor.
// Contents:
//   ERR_W and the bit index of each error class in a channel's error vector.
//   ptr_t is a wide container for pointers of any width up to MAX_PW bits.
//   The helpers take the real pointer width as an argument, so one function
//   serves every SIZE_LOG2.
package fifo_mon_pkg;

  localparam int ERR_W         = 6;
  localparam int ERR_STALL     = 0;
  localparam int ERR_INCR      = 1;
  localparam int ERR_HOLD      = 2;
  localparam int ERR_GRAY_ENC  = 3;
  localparam int ERR_GRAY_STEP = 4;
  localparam int ERR_FULL      = 5;

  localparam int MAX_PW = 33;
  typedef logic [MAX_PW-1:0] ptr_t;

  // The shift wraps to zero when pw == MAX_PW, which still yields all ones.
  function automatic ptr_t ptr_mask(input int pw);
    return (ptr_t'(1) << pw) - ptr_t'(1);
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin, input int pw);
    ptr_t b;
    b = bin & ptr_mask(pw);
    return (b >> 1) ^ b;
  endfunction

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  function automatic logic popcount_gt1(input ptr_t x, input int pw);
    ptr_t v;
    v = x & ptr_mask(pw);
    return (v & (v - ptr_t'(1))) != '0;
  endfunction

  // Full occurs when the write gray pointer equals the synced read pointer
  // with its two MSBs inverted, meaning it is exactly one lap ahead.
  function automatic logic full_from_ptrs(input ptr_t gray, input ptr_t sync2,
                                          input int pw);
    ptr_t inv;
    inv = ptr_t'(3) << (pw - 2);
    return (gray & ptr_mask(pw)) == ((sync2 ^ inv) & ptr_mask(pw));
  endfunction

endpackage

// File: rtl/fifo_ptr_chk.sv
// Single-channel write-pointer checker.
// It registers the previous en/full/bin/gray sample and produces the 6-bit
// error vector for the current cycle, without gating by mon_en.
// Ports:
//   clk_i, rst_ni  write clock and asynchronous active-low reset
//   en_i, full_i   write request and full flag of this channel
//   bin_i, gray_i  binary and gray write pointers
//   sync2_i        read pointer (gray) synchronised into the write domain
//   err_o          combinational error vector, indexed by ERR_* bit positions
module fifo_ptr_chk
  import fifo_mon_pkg::*;
#(
  parameter int SIZE_LOG2 = 5,
  localparam int PW = SIZE_LOG2 + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             full_i,
  input  logic [PW-1:0]    bin_i,
  input  logic [PW-1:0]    gray_i,
  input  logic [PW-1:0]    sync2_i,
  output logic [ERR_W-1:0] err_o
);

  logic          prev_valid_q;
  logic          prev_en_q;
  logic          prev_full_q;
  logic [PW-1:0] prev_bin_q;
  logic [PW-1:0] prev_gray_q;
  logic [PW-1:0] bin_inc;

  // History keeps updating while checking is disabled, so that re-enabling
  // compares against a fresh sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_valid_q <= 1'b0;
      prev_en_q    <= 1'b0;
      prev_full_q  <= 1'b0;
      prev_bin_q   <= '0;
      prev_gray_q  <= '0;
    end else begin
      prev_valid_q <= 1'b1;
      prev_en_q    <= en_i;
      prev_full_q  <= full_i;
      prev_bin_q   <= bin_i;
      prev_gray_q  <= gray_i;
    end
  end

  // The addition wraps at PW bits, so all-ones followed by zero is legal.
  assign bin_inc = prev_bin_q + PW'(1);

  always_comb begin
    err_o = '0;
    err_o[ERR_STALL]     = prev_valid_q && prev_en_q && prev_full_q &&
                           ((bin_i != prev_bin_q) || (gray_i != prev_gray_q));
    err_o[ERR_INCR]      = prev_valid_q && prev_en_q && !prev_full_q &&
                           (bin_i != bin_inc);
    err_o[ERR_HOLD]      = prev_valid_q && !prev_en_q && (bin_i != prev_bin_q);
    err_o[ERR_GRAY_ENC]  = ptr_t'(gray_i) != bin2gray(ptr_t'(bin_i), PW);
    err_o[ERR_GRAY_STEP] = prev_valid_q &&
                           popcount_gt1(ptr_t'(gray_i ^ prev_gray_q), PW);
    err_o[ERR_FULL]      = full_i != full_from_ptrs(ptr_t'(gray_i),
                                                    ptr_t'(sync2_i), PW);
  end

endmodule

// File: rtl/fifo_ptr_monitor.sv
// Multi-channel async-FIFO write-side pointer integrity monitor.
// Each channel has its own fifo_ptr_chk. This level gates the channel error
// vectors with mon_en, then keeps the sticky flags, a saturating count of
// error cycles and a capture of the first error.
// Ports:
//   write_clk, write_rst_n       clock and asynchronous active-low reset
//   mon_en                       0 suppresses recording of new errors
//   clear_err                    synchronous clear; new errors override it
//   p_write_en, p_write_full     per-channel write request and full flag
//   r_write_ptr_bin/_gray        per-channel write pointers, PW bits each
//   r_read_ptr_gray_sync2        per-channel synchronised read pointer
//   err_flags, err_any           sticky per-channel error vectors and their OR
//   err_cnt                      saturating count of cycles with new errors
//   first_err_valid/_ch/_code    capture of the first error event
module fifo_ptr_monitor
  import fifo_mon_pkg::*;
#(
  parameter int SIZE_LOG2 = 5,
  parameter int NUM_CH    = 1,
  parameter int ERR_CNT_W = 8,
  localparam int PW   = SIZE_LOG2 + 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    write_clk,
  input  logic                    write_rst_n,
  input  logic                    mon_en,
  input  logic                    clear_err,
  input  logic [NUM_CH-1:0]       p_write_en,
  input  logic [NUM_CH-1:0]       p_write_full,
  input  logic [NUM_CH*PW-1:0]    r_write_ptr_bin,
  input  logic [NUM_CH*PW-1:0]    r_write_ptr_gray,
  input  logic [NUM_CH*PW-1:0]    r_read_ptr_gray_sync2,
  output logic [NUM_CH*ERR_W-1:0] err_flags,
  output logic                    err_any,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic                    first_err_valid,
  output logic [CH_W-1:0]         first_err_ch,
  output logic [ERR_W-1:0]        first_err_code
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic [ERR_W-1:0]        raw_err [NUM_CH];
  logic [ERR_W-1:0]        new_err [NUM_CH];

  logic [NUM_CH*ERR_W-1:0] flags_q, flags_d;
  logic                    any_q, any_d;
  logic [ERR_CNT_W-1:0]    cnt_q, cnt_d;
  logic                    fv_q, fv_d;
  logic [CH_W-1:0]         fch_q, fch_d;
  logic [ERR_W-1:0]        fcode_q, fcode_d;

  logic                    any_new;
  logic                    cap_load;
  logic [CH_W-1:0]         sel_ch;
  logic [ERR_W-1:0]        sel_code;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_ptr_chk #(
      .SIZE_LOG2(SIZE_LOG2)
    ) u_chk (
      .clk_i  (write_clk),
      .rst_ni (write_rst_n),
      .en_i   (p_write_en[c]),
      .full_i (p_write_full[c]),
      .bin_i  (r_write_ptr_bin[c*PW +: PW]),
      .gray_i (r_write_ptr_gray[c*PW +: PW]),
      .sync2_i(r_read_ptr_gray_sync2[c*PW +: PW]),
      .err_o  (raw_err[c])
    );
    assign new_err[c] = mon_en ? raw_err[c] : '0;
  end

  // Scanning from the top channel down leaves the lowest failing channel
  // selected when several fail in the same cycle.
  always_comb begin
    any_new  = 1'b0;
    sel_ch   = '0;
    sel_code = '0;
    flags_d  = clear_err ? '0 : flags_q;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      flags_d[c*ERR_W +: ERR_W] = flags_d[c*ERR_W +: ERR_W] | new_err[c];
      if (|new_err[c]) begin
        any_new  = 1'b1;
        sel_ch   = CH_W'(c);
        sel_code = new_err[c];
      end
    end
  end

  // New errors win over clear_err: the counter restarts at 1 and the capture
  // reloads instead of emptying.
  assign cap_load = any_new && (!fv_q || clear_err);

  always_comb begin
    any_d = |flags_d;

    if (any_new)        cnt_d = clear_err ? ERR_CNT_W'(1) : sat_inc(cnt_q);
    else if (clear_err) cnt_d = '0;
    else                cnt_d = cnt_q;

    fv_d    = fv_q;
    fch_d   = fch_q;
    fcode_d = fcode_q;
    if (cap_load) begin
      fv_d    = 1'b1;
      fch_d   = sel_ch;
      fcode_d = sel_code;
    end else if (clear_err) begin
      fv_d    = 1'b0;
      fch_d   = '0;
      fcode_d = '0;
    end
  end

  // Result registers: one cycle after the offending sample.
  always_ff @(posedge write_clk or negedge write_rst_n) begin
    if (!write_rst_n) begin
      flags_q <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fch_q   <= '0;
      fcode_q <= '0;
    end else begin
      flags_q <= flags_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fch_q   <= fch_d;
      fcode_q <= fcode_d;
    end
  end

  assign err_flags       = flags_q;
  assign err_any         = any_q;
  assign err_cnt         = cnt_q;
  assign first_err_valid = fv_q;
  assign first_err_ch    = fch_q;
  assign first_err_code  = fcode_q;

endmodule

// File: doc/fifo_ptr_monitor.md
Name: fifo_ptr_monitor

Overview:
Synthesizable, single-clock, multi-channel integrity monitor for async-FIFO write-side pointer logic. It is the generalised successor of the simulation-only write-domain assertion checker. It is parametrised in pointer width and channel count, adds a full-flag correctness check, and keeps sticky error flags, a saturating error counter and first-error capture. These results stay observable in silicon and in emulation. One instance sits in the write domain beside each FIFO group.

Parameters:
SIZE_LOG2, 5, log2 of FIFO depth; pointers are PW = SIZE_LOG2+1 bits
NUM_CH, 1, number of monitored FIFO channels (1..32)
ERR_CNT_W, 8, error counter width

Ports:
write_clk  in  1  monitor clock (FIFO write clock)
write_rst_n  in  1  asynchronous active-low reset
mon_en  in  1  checking enable; 0 = no new errors recorded
clear_err  in  1  synchronous clear of flags, counter and capture
p_write_en  in  NUM_CH  per-channel write request
p_write_full  in  NUM_CH  per-channel full flag
r_write_ptr_bin  in  NUM_CH*PW  binary write pointers, channel c at [c*PW +: PW]
r_write_ptr_gray  in  NUM_CH*PW  gray write pointers
r_read_ptr_gray_sync2  in  NUM_CH*PW  synchronised read pointers (gray)
err_flags  out  NUM_CH*6  sticky per-channel error vector, channel c at [c*6 +: 6]
err_any  out  1  OR of all err_flags
err_cnt  out  ERR_CNT_W  saturating count of cycles with at least one new error
first_err_valid  out  1  capture holds data
first_err_ch  out  $clog2(NUM_CH) max 1  channel of the first error
first_err_code  out  6  error vector of the first error

Behaviour:
- Reset: asynchronous assertion and synchronous deassertion (as seen at write_clk). All outputs are 0. The internal prev_valid bit is 0, and all sampled previous values are 0.
- Each cycle, every channel's en, full, bin and gray are registered as "prev". prev_valid is set 1 on the first clock after reset.
- Error bits per channel, evaluated combinationally on the current inputs plus the prev registers. Bits 0, 1, 2 and 4 require prev_valid=1.
  - bit0 STALL: prev en && prev full && (bin != prev bin || gray != prev gray).
  - bit1 INCR: prev en && !prev full && bin != prev bin + 1, mod 2^PW. Wrap from all-ones to 0 is legal.
  - bit2 HOLD: !prev en && bin != prev bin.
  - bit3 GRAY_ENC: gray != (bin >> 1) ^ bin.
  - bit4 GRAY_STEP: popcount(gray ^ prev gray) > 1.
  - bit5 FULL: full != (gray == {~sync2[PW-1:PW-2], sync2[PW-3:0]}). When SIZE_LOG2 == 1, the compare is on {~sync2[1:0]}.
- new_err[c] = mon_en ? bits : 0.
- All registered outputs update one cycle after the offending sample, so latency is 1 clock.
- err_flags: new_err ORed into the register, sticky.
- err_cnt: +1 per cycle when any new_err bit is set, regardless of how many channels or bits. Saturates at all-ones and never wraps.
- First-error capture: loaded only when first_err_valid == 0 and any new_err bit is set. When several channels fail together, the lowest channel index wins. first_err_code takes that channel's full vector. The capture holds until clear or reset.
- clear_err=1: flags, counter and capture return to 0. If new errors occur in the same cycle, they are loaded instead: set wins over clear. For the counter this means a result of 1 rather than +1; for the capture it means it loads.
- mon_en=0: the prev registers still update, so re-enabling raises no false INCR/HOLD errors.
- err_any is the registered OR, aligned with err_flags.
- Reset mid-operation: everything clears and prev_valid returns to 0. The first post-reset sample therefore only checks bits 3 and 5.

Decomposition:
- Package fifo_mon_pkg: ERR_W=6; localparams for the bit indices ERR_STALL..ERR_FULL; functions bin2gray, popcount-gt-1 and full_from_ptrs, each parametrised by width.
- One sub-module, fifo_ptr_chk: a single channel holding its prev registers and producing the 6-bit error vector. It is instantiated NUM_CH times with generate.
- The top level handles aggregation, the counter and the capture.

Test Plan:
- Legal traffic, NUM_CH=2, SIZE_LOG2=3: 40 writes with wrap 15->0 and full asserted at the correct pointer -> err_any=0, err_cnt=0.
- Channel 1 bin steps 4->6 with en=1, full=0 -> next cycle err_flags[1*6+1]=1, first_err_ch=1, first_err_code=6'b000010, err_cnt=1.
- Channel 0 gray 0b0000->0b0011 with a stalled pointer -> bits STALL|GRAY_STEP|GRAY_ENC; code 6'b011001 once full=1, en=1 are set up.
- ERR_CNT_W=2 with a GRAY_ENC fault held 6 cycles -> err_cnt saturates at 3. clear_err in a cycle where the fault is still present -> err_cnt=1, flags remain set.
- Both channels fault in the same cycle -> first_err_ch=0. A later fault on ch1 leaves the capture unchanged.
- mon_en=0 during a bad increment, then mon_en=1 with legal traffic -> no flags. Async reset mid-burst -> all outputs 0 immediately, and no error on the first post-reset cycle.
